// File: rtl/fb_pkg.sv
// fb_pkg: shared state encoding, default frame geometry and coordinate types
package fb_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  localparam int DEF_WIDTH   = 640;
  localparam int DEF_HEIGHT  = 480;
  localparam int DEF_COLOR_W = 1;
  typedef logic [15:0] coord_t;
  typedef struct packed {
    coord_t x;
    coord_t y;
  } coord_pair_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y raster walk over an inclusive rectangle with a last-pixel flag
module raster_counter #(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_adv,
  input  logic [XW-1:0] i_x0,
  input  logic [XW-1:0] i_x1,
  input  logic [YW-1:0] i_y0,
  input  logic [YW-1:0] i_y1,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);
  logic [XW-1:0] r_x, r_x0, r_x1;
  logic [YW-1:0] r_y, r_y1;
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = r_x == r_x1 && r_y == r_y1;
  // Advancing is suppressed on the last pixel so the walk never runs past the bottom row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x  <= '0;
      r_y  <= '0;
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
    end else if (i_load) begin
      r_x  <= i_x0;
      r_y  <= i_y0;
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
    end else if (i_adv && !o_last) begin
      r_x <= r_x == r_x1 ? r_x0 : r_x + 1'b1;
      r_y <= r_x == r_x1 ? r_y + 1'b1 : r_y;
    end
  end
endmodule

// File: rtl/fb_region_filler.sv
// fb_region_filler: raster fill of a full or clipped frame-buffer rectangle
// with ready/valid writes, abort, a done pulse and a sticky cleared flag.
module fb_region_filler
  import fb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int XW      = $clog2(WIDTH),
  parameter int YW      = $clog2(HEIGHT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               full_frame,
  input  logic [XW-1:0]      x0,
  input  logic [YW-1:0]      y0,
  input  logic [XW-1:0]      x1,
  input  logic [YW-1:0]      y1,
  input  logic [COLOR_W-1:0] color,
  input  logic               abort,
  input  logic               wr_ready,
  output logic               wr_en,
  output logic [XW-1:0]      wr_x,
  output logic [YW-1:0]      wr_y,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               cleared
);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  state_t               r_state, w_next;
  logic                 r_wr_en, r_busy, r_done, r_cleared;
  logic [COLOR_W-1:0]   r_data;
  logic [XW-1:0]        w_rx0, w_rx1;
  logic [YW-1:0]        w_ry0, w_ry1;
  logic                 w_empty, w_load, w_last;
  // Bottom-right is clipped to the frame, so an origin outside the frame
  // always lands beyond the clipped edge and reads as an empty region.
  always_comb begin
    w_rx0   = full_frame ? '0 : x0;
    w_ry0   = full_frame ? '0 : y0;
    w_rx1   = (full_frame || x1 > XMAX) ? XMAX : x1;
    w_ry1   = (full_frame || y1 > YMAX) ? YMAX : y1;
    w_empty = w_rx0 > w_rx1 || w_ry0 > w_ry1;
  end
  assign w_load = r_state == IDLE && start;
  always_comb begin
    w_next = r_state == IDLE ? (start ? (w_empty ? DONE : FILL) : IDLE) :
             r_state == FILL ? (abort ? IDLE : (wr_ready && w_last) ? DONE : FILL) :
             IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cleared <= 1'b0;
      r_data    <= '0;
    end else begin
      r_state   <= w_next;
      r_wr_en   <= w_next == FILL;
      r_busy    <= w_next == FILL;
      r_done    <= r_state == DONE;
      r_cleared <= w_load ? 1'b0 : (r_state == DONE ? 1'b1 : r_cleared);
      r_data    <= w_load ? color : r_data;
    end
  end
  raster_counter #(.XW(XW), .YW(YW)) u_raster (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_adv  (r_state == FILL && wr_ready),
    .i_x0   (w_rx0),
    .i_x1   (w_rx1),
    .i_y0   (w_ry0),
    .i_y1   (w_ry1),
    .o_x    (wr_x),
    .o_y    (wr_y),
    .o_last (w_last)
  );
  assign wr_en   = r_wr_en;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cleared = r_cleared;
  assign wr_data = r_data;
endmodule

// File: tb/tb_fb_region_filler.sv
// tb_fb_region_filler: directed and random fills on a 6x3 frame (non power of two so
// clipping is reachable) checked against a queue-based raster reference model.
module tb_fb_region_filler;
  localparam int W = 6, H = 3, CW = 1, XW = 3, YW = 2;
  logic clk = 1'b0;
  logic reset, start, full_frame, abort, wr_ready;
  logic wr_en, busy, done, cleared;
  logic [XW-1:0] x0, x1, wr_x;
  logic [YW-1:0] y0, y1, wr_y;
  logic [CW-1:0] color, wr_data;
  int n_cmp = 0, n_bad = 0;
  int q[$];
  always #5 clk = ~clk;
  fb_region_filler #(.WIDTH(W), .HEIGHT(H), .COLOR_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .full_frame(full_frame),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .abort(abort),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .busy(busy), .done(done), .cleared(cleared)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] pix_now();
    return 32'({wr_x, wr_y, wr_data});
  endfunction
  // Reference: every pixel of the clipped rectangle in raster order, encoded x*8+y*2+colour.
  task automatic model(input bit ff, input int a0, b0, a1, b1, c);
    int rx0, ry0, rx1, ry1;
    q.delete();
    rx0 = ff ? 0 : a0;
    ry0 = ff ? 0 : b0;
    rx1 = ff ? W - 1 : (a1 < W - 1 ? a1 : W - 1);
    ry1 = ff ? H - 1 : (b1 < H - 1 ? b1 : H - 1);
    for (int y = ry0; y <= ry1; y++)
      for (int x = rx0; x <= rx1; x++) q.push_back(x * 8 + y * 2 + c);
  endtask
  // mode: 0 ready always, 1 toggling, 2 random; abort_at < 0 means never; noise pulses start mid-fill
  task automatic run(input bit ff, input int a0, b0, a1, b1, c, mode, abort_at, input bit noise);
    int n = 0, last = 0, ab_cyc = 0, exp_n, cyc, quiet;
    bit saw_done = 0, hold = 0;
    logic [31:0] held = '0, exp;
    model(ff, a0, b0, a1, b1, c);
    exp_n = q.size();
    @(negedge clk);
    start = 1'b1; full_frame = ff; abort = 1'b0;
    x0 = XW'(a0); y0 = YW'(b0); x1 = XW'(a1); y1 = YW'(b1); color = CW'(c);
    @(negedge clk);
    start = 1'b0;
    check("lat_en", 32'(wr_en), 32'(exp_n > 0));
    check("lat_busy", 32'(busy), 32'(exp_n > 0));
    if (exp_n > 0) check("lat_pix", pix_now(), q[0]);
    for (cyc = 1; cyc <= 300; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (ab_cyc > 0) begin
        check("abort_stop", 32'({wr_en, busy, done}), 0);
        break;
      end
      if (done) begin
        saw_done = 1;
        break;
      end
      if (hold) check("hold", pix_now(), held);
      abort = abort_at >= 0 && n == abort_at && wr_en;
      if (abort) ab_cyc = cyc;
      wr_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc % 2) : 1'($urandom % 2);
      start = noise && q.size() > 1 && $urandom_range(0, 2) == 0;
      if (start) begin
        x0 = XW'($urandom); y0 = YW'($urandom); x1 = XW'($urandom); y1 = YW'($urandom);
        full_frame = 1'($urandom); color = CW'($urandom);
      end
      if (wr_en && wr_ready) begin
        exp = '1;
        if (q.size() > 0) exp = q.pop_front();
        check("pix", pix_now(), exp);
        n++;
        last = cyc;
      end
      hold = wr_en && !wr_ready;
      held = pix_now();
    end
    abort = 1'b0;
    start = 1'b0;
    if (ab_cyc > 0) begin
      check("abort_nodone", 32'(saw_done), 0);
      quiet = 0;
      repeat (4) begin
        @(negedge clk);
        quiet += int'(done | wr_en | cleared);
      end
      check("abort_quiet", quiet, 0);
    end else begin
      check("done_seen", 32'(saw_done), 1);
      check("nwrites", n, exp_n);
      check("done_lat", cyc - last, 2);
      @(negedge clk);
      check("post_done", 32'({done, busy, wr_en, cleared}), 32'b0001);
    end
  endtask
  initial begin
    int quiet, ex0, ex1;
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b0; full_frame = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color = '0;
    @(negedge clk);
    check("reset_vals", 32'({wr_en, busy, done, cleared, wr_x, wr_y, wr_data}), 0);
    reset = 1'b0;
    run(1, 0, 0, 0, 0, 1, 0, -1, 0);
    run(0, 2, 1, 4, 2, 1, 1, -1, 0);
    run(0, 4, 1, 7, 3, 0, 0, -1, 0);
    run(0, 5, 0, 3, 2, 1, 0, -1, 0);
    run(0, 6, 0, 7, 1, 1, 0, -1, 0);
    run(1, 0, 0, 0, 0, 1, 0, 10, 0);
    run(0, 1, 1, 3, 2, 1, 0, 5, 0);
    run(1, 0, 0, 0, 0, 0, 2, -1, 1);
    @(negedge clk);
    start = 1'b1; full_frame = 1'b1;
    @(negedge clk);
    start = 1'b0; wr_ready = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_mid", 32'({wr_en, busy, done, cleared, wr_x, wr_y, wr_data}), 0);
    @(negedge clk);
    reset = 1'b0;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      quiet += int'(wr_en | busy | done);
    end
    check("reset_quiet", quiet, 0);
    for (int i = 0; i < 30; i++) begin
      ex0 = $urandom_range(0, 7);
      ex1 = $urandom_range(0, 7);
      run($urandom_range(0, 3) == 0, ex0, $urandom_range(0, 3), ex1, $urandom_range(0, 3),
          $urandom_range(0, 1), 2, $urandom_range(0, 4) == 0 ? $urandom_range(0, 12) : -1, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
